// File: rtl/me_sad_selector_if.sv
// Candidate SAD stream, search control and best-match result bundle for the
// motion-estimation min-SAD selector.
interface me_sad_selector_if #(
  parameter int unsigned SAD_WIDTH = 16,
  parameter int unsigned RANGE     = 24
);
  localparam int unsigned W         = 2 * RANGE + 1;
  localparam int unsigned NUM_CAND  = W * W;
  localparam int unsigned CNT_WIDTH = $clog2(NUM_CAND);
  localparam int unsigned MV_WIDTH  = $clog2(RANGE + 1) + 1;

  logic                 start_i;
  logic                 early_en_i;
  logic [SAD_WIDTH-1:0] thresh_i;
  logic                 sad_valid_i;
  logic [SAD_WIDTH-1:0] sad_i;
  logic                 busy_o;
  logic                 stop_o;
  logic                 done_o;
  logic                 early_hit_o;
  logic [SAD_WIDTH-1:0] min_sad_o;
  logic [CNT_WIDTH-1:0] min_cnt_o;
  logic [MV_WIDTH-1:0]  mv_x_o;
  logic [MV_WIDTH-1:0]  mv_y_o;

  modport slave (
    input  start_i, early_en_i, thresh_i, sad_valid_i, sad_i,
    output busy_o, stop_o, done_o, early_hit_o, min_sad_o, min_cnt_o, mv_x_o, mv_y_o
  );

  modport master (
    output start_i, early_en_i, thresh_i, sad_valid_i, sad_i,
    input  busy_o, stop_o, done_o, early_hit_o, min_sad_o, min_cnt_o, mv_x_o, mv_y_o
  );
endinterface

// File: rtl/me_sad_selector.sv
// Streaming min-SAD selector: tracks the best candidate over a raster search
// window with a zero-MV bias and optional threshold early termination.
module me_sad_selector #(
  parameter int unsigned SAD_WIDTH = 16,
  parameter int unsigned RANGE     = 24,
  parameter int unsigned ZMV_BIAS  = 8
) (
  input logic              clk,
  input logic              rst,
  me_sad_selector_if.slave bus
);
  localparam int unsigned W         = 2 * RANGE + 1;
  localparam int unsigned NUM_CAND  = W * W;
  localparam int unsigned CNT_WIDTH = $clog2(NUM_CAND);
  localparam int unsigned MV_WIDTH  = $clog2(RANGE + 1) + 1;
  localparam int unsigned XY_WIDTH  = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [XY_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [SAD_WIDTH-1:0] best_eff_q, best_eff_d, best_raw_q, best_raw_d;
  logic [CNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
  logic [XY_WIDTH-1:0]  best_x_q, best_x_d, best_y_q, best_y_d;
  logic                 early_en_q, early_en_d;
  logic [SAD_WIDTH-1:0] thresh_q, thresh_d;
  logic                 busy_q, busy_d, stop_q, stop_d, done_q, done_d;
  logic                 early_hit_q, early_hit_d;
  logic [SAD_WIDTH-1:0] min_sad_q, min_sad_d;
  logic [CNT_WIDTH-1:0] min_cnt_q, min_cnt_d;
  logic [MV_WIDTH-1:0]  mv_x_q, mv_x_d, mv_y_q, mv_y_d;

  logic                 beat, is_centre, better, hit, last, term;
  logic [SAD_WIDTH-1:0] eff;

  // Centre candidate gets a saturating bias so zero motion wins near-ties.
  assign beat      = (state_q == RUN) && bus.sad_valid_i;
  assign is_centre = (x_q == XY_WIDTH'(RANGE)) && (y_q == XY_WIDTH'(RANGE));
  assign eff       = !is_centre ? bus.sad_i :
                     (bus.sad_i > SAD_WIDTH'(ZMV_BIAS)) ? bus.sad_i - SAD_WIDTH'(ZMV_BIAS) : '0;
  assign better    = eff < best_eff_q;
  assign hit       = early_en_q && (eff <= thresh_q);
  assign last      = cnt_q == CNT_WIDTH'(NUM_CAND - 1);
  assign term      = beat && (hit || last);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = RUN;
      RUN:     if (term) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    best_eff_d  = best_eff_q;
    best_raw_d  = best_raw_q;
    best_cnt_d  = best_cnt_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    early_en_d  = early_en_q;
    thresh_d    = thresh_q;
    early_hit_d = early_hit_q;
    min_sad_d   = min_sad_q;
    min_cnt_d   = min_cnt_q;
    mv_x_d      = mv_x_q;
    mv_y_d      = mv_y_q;
    busy_d      = (state_d == RUN);
    stop_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i) begin
        cnt_d       = '0;
        x_d         = '0;
        y_d         = '0;
        best_eff_d  = '1;
        best_raw_d  = '0;
        best_cnt_d  = '0;
        best_x_d    = '0;
        best_y_d    = '0;
        early_en_d  = bus.early_en_i;
        thresh_d    = bus.thresh_i;
        early_hit_d = 1'b0;
      end
      RUN: if (beat) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (x_q == XY_WIDTH'(W - 1)) begin
          x_d = '0;
          y_d = y_q + XY_WIDTH'(1);
        end else begin
          x_d = x_q + XY_WIDTH'(1);
        end
        if (better) begin
          best_eff_d = eff;
          best_raw_d = bus.sad_i;
          best_cnt_d = cnt_q;
          best_x_d   = x_q;
          best_y_d   = y_q;
        end
        // Results are registered here so they are valid alongside done.
        if (term) begin
          done_d      = 1'b1;
          stop_d      = hit;
          early_hit_d = hit;
          min_sad_d   = best_raw_d;
          min_cnt_d   = best_cnt_d;
          mv_x_d      = MV_WIDTH'(best_x_d) - MV_WIDTH'(RANGE);
          mv_y_d      = MV_WIDTH'(best_y_d) - MV_WIDTH'(RANGE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      best_eff_q  <= '1;
      best_raw_q  <= '0;
      best_cnt_q  <= '0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      early_en_q  <= 1'b0;
      thresh_q    <= '0;
      early_hit_q <= 1'b0;
      min_sad_q   <= '0;
      min_cnt_q   <= '0;
      mv_x_q      <= '0;
      mv_y_q      <= '0;
      busy_q      <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      best_eff_q  <= best_eff_d;
      best_raw_q  <= best_raw_d;
      best_cnt_q  <= best_cnt_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      early_en_q  <= early_en_d;
      thresh_q    <= thresh_d;
      early_hit_q <= early_hit_d;
      min_sad_q   <= min_sad_d;
      min_cnt_q   <= min_cnt_d;
      mv_x_q      <= mv_x_d;
      mv_y_q      <= mv_y_d;
      busy_q      <= busy_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.stop_o      = stop_q;
  assign bus.done_o      = done_q;
  assign bus.early_hit_o = early_hit_q;
  assign bus.min_sad_o   = min_sad_q;
  assign bus.min_cnt_o   = min_cnt_q;
  assign bus.mv_x_o      = mv_x_q;
  assign bus.mv_y_o      = mv_y_q;
endmodule

// File: tb/tb_me_sad_selector.sv
// Bench for me_sad_selector: directed and randomized searches against a
// plain-arithmetic best-match model, including gaps, early hits and reset.
module tb_me_sad_selector;
  localparam int SW   = 16;
  localparam int RG   = 2;
  localparam int BIAS = 8;
  localparam int W    = 2 * RG + 1;
  localparam int NC   = W * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_sad_selector_if #(.SAD_WIDTH(SW), .RANGE(RG)) bus();
  me_sad_selector #(.SAD_WIDTH(SW), .RANGE(RG), .ZMV_BIAS(BIAS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int sads[NC];
  int exp_cnt, exp_sad, exp_term;
  bit exp_early;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: scan the window in raster order, keep the first strict minimum
  // of the biased SAD, stop at the first candidate at or under the threshold.
  function automatic void model(input bit en, input int thr);
    int best;
    int eff;
    best      = (1 << SW) - 1;
    exp_cnt   = 0;
    exp_sad   = 0;
    exp_early = 1'b0;
    exp_term  = NC - 1;
    for (int i = 0; i < NC; i++) begin
      if ((i % W) == RG && (i / W) == RG) eff = (sads[i] > BIAS) ? sads[i] - BIAS : 0;
      else                                eff = sads[i];
      if (eff < best) begin
        best    = eff;
        exp_cnt = i;
        exp_sad = sads[i];
      end
      if (en && eff <= thr) begin
        exp_early = 1'b1;
        exp_term  = i;
        break;
      end
    end
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_done"},  32'(bus.done_o), 32'd1);
    check({tag, "_stop"},  32'(bus.stop_o), 32'(exp_early));
    check({tag, "_ehit"},  32'(bus.early_hit_o), 32'(exp_early));
    check({tag, "_busy"},  32'(bus.busy_o), 32'd0);
    check({tag, "_sad"},   32'(bus.min_sad_o), 32'(exp_sad));
    check({tag, "_cnt"},   32'(bus.min_cnt_o), 32'(exp_cnt));
    check({tag, "_mvx"},   32'($signed(bus.mv_x_o)), 32'((exp_cnt % W) - RG));
    check({tag, "_mvy"},   32'($signed(bus.mv_y_o)), 32'((exp_cnt / W) - RG));
  endtask

  task automatic run_search(input bit en, input int thr, input bit gapped, input string tag);
    int  i   = 0;
    int  cyc = 0;
    bit  beat;
    model(en, thr);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.early_en_i = en;
    bus.thresh_i   = 16'(thr);
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.early_en_i = ~en;
    bus.thresh_i   = 16'($urandom);
    check({tag, "_busy_run"}, 32'(bus.busy_o), 32'd1);
    while (i <= exp_term && cyc < 200) begin
      beat            = !(gapped && (cyc % 2) == 1);
      bus.sad_valid_i = beat;
      bus.sad_i       = beat ? 16'(sads[i]) : 16'($urandom_range(0, 3));
      bus.start_i     = gapped && !beat;
      @(negedge clk);
      cyc++;
      if (beat) begin
        if (i == exp_term) check_results(tag);
        else               check({tag, "_nodone"}, 32'(bus.done_o), 32'd0);
        i++;
      end
    end
    if (i <= exp_term) check({tag, "_timeout"}, 32'(i), 32'(exp_term + 1));
    // Beats and a start arriving after completion must be ignored.
    for (int k = 0; k < 3; k++) begin
      bus.sad_valid_i = 1'b1;
      bus.sad_i       = '0;
      bus.start_i     = gapped && (k == 0);
      @(negedge clk);
      check({tag, "_post_done"}, 32'(bus.done_o), 32'd0);
      check({tag, "_post_cnt"},  32'(bus.min_cnt_o), 32'(exp_cnt));
      check({tag, "_post_ehit"}, 32'(bus.early_hit_o), 32'(exp_early));
    end
    bus.sad_valid_i = 1'b0;
    bus.start_i     = 1'b0;
  endtask

  task automatic fill_s1();
    for (int i = 0; i < NC; i++) sads[i] = 100;
    sads[17] = 40;
  endtask

  initial begin
    int seen;
    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.early_en_i  = 1'b0;
    bus.thresh_i    = '0;
    bus.sad_valid_i = 1'b0;
    bus.sad_i       = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_cnt",  32'(bus.min_cnt_o), 32'd0);
    check("rst_mvx",  32'(bus.mv_x_o), 32'd0);
    rst = 1'b0;

    fill_s1();
    run_search(1'b0, 0, 1'b0, "s1");

    for (int i = 0; i < NC; i++) sads[i] = 200;
    sads[3] = 50;
    sads[9] = 50;
    run_search(1'b0, 0, 1'b0, "s2_tie");

    for (int i = 0; i < NC; i++) sads[i] = 200;
    sads[12] = 55;
    sads[4]  = 50;
    run_search(1'b0, 0, 1'b0, "s3_bias");

    for (int i = 0; i < NC; i++) sads[i] = $urandom_range(1, 300);
    sads[12] = 5;
    run_search(1'b0, 0, 1'b0, "s3_sat");

    for (int i = 0; i < NC; i++) sads[i] = (i < 6) ? 90 : $urandom_range(0, 200);
    sads[6] = 30;
    run_search(1'b1, 30, 1'b0, "s4_early");

    fill_s1();
    run_search(1'b0, 0, 1'b1, "s5_gap");

    // Reset in the middle of a search aborts it silently.
    fill_s1();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sad_valid_i = 1'b1;
      bus.sad_i       = 16'(sads[i]);
      @(negedge clk);
    end
    bus.sad_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_busy", 32'(bus.busy_o), 32'd0);
    check("s6_stop", 32'(bus.stop_o), 32'd0);
    check("s6_done", 32'(bus.done_o), 32'd0);
    check("s6_ehit", 32'(bus.early_hit_o), 32'd0);
    check("s6_sad",  32'(bus.min_sad_o), 32'd0);
    check("s6_cnt",  32'(bus.min_cnt_o), 32'd0);
    check("s6_mvx",  32'(bus.mv_x_o), 32'd0);
    check("s6_mvy",  32'(bus.mv_y_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      bus.sad_valid_i = 1'b1;
      bus.sad_i       = 16'($urandom_range(0, 50));
      @(negedge clk);
      if (bus.done_o) seen++;
    end
    bus.sad_valid_i = 1'b0;
    check("s6_no_done", 32'(seen), 32'd0);
    run_search(1'b0, 0, 1'b0, "s6_rerun");

    for (int r = 0; r < 8; r++) begin
      bit en;
      for (int i = 0; i < NC; i++) sads[i] = $urandom_range(0, 400);
      en = 1'($urandom_range(0, 1));
      run_search(en, $urandom_range(0, 60), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/me_sad_selector.md
Name: me_sad_selector

Overview:
- Streaming best-match selector for the full-search motion estimator, the parametrised successor of the control unit's min-SAD compare logic.
- Consumes one SAD per candidate position, in raster order, from the PE array.
- Tracks the minimum with a zero-motion-vector bias and optional early termination, then reports both the candidate index and a signed motion vector (mv_x, mv_y).

Parameters:
- SAD_WIDTH, 16, bit width of sad, thresh and min_sad.
- RANGE, 24, search range per axis; W = 2*RANGE+1 candidates per row; NUM_CAND = W*W.
- ZMV_BIAS, 8, amount subtracted (with saturation at 0) from the centre candidate's SAD before comparison.
- CNT_WIDTH, $clog2(NUM_CAND), derived (localparam), width of min_cnt.
- MV_WIDTH, $clog2(RANGE+1)+1, derived (localparam), signed width of mv_x and mv_y.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a search; honoured only in IDLE.
- early_en  input  1  enables threshold early termination; sampled at start.
- thresh  input  SAD_WIDTH  early-termination threshold; sampled at start.
- sad_valid  input  1  sad carries the next candidate's SAD.
- sad  input  SAD_WIDTH  unsigned SAD of the current candidate.
- busy  output  1  high in RUN.
- stop  output  1  one-cycle pulse telling upstream to abort on an early hit.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- early_hit  output  1  the last search ended by threshold; held until next start.
- min_sad  output  SAD_WIDTH  raw (unbiased) SAD of the winning candidate.
- min_cnt  output  CNT_WIDTH  raster index of the winner, y*W + x.
- mv_x  output  MV_WIDTH  signed, equal to x - RANGE.
- mv_y  output  MV_WIDTH  signed, equal to y - RANGE.

Behaviour:
- Reset: the FSM goes to IDLE. busy, stop, done, early_hit, min_sad, min_cnt, mv_x and mv_y are all 0. Reset mid-RUN aborts the search with no done.
- FSM states are IDLE, RUN and DONE.
- IDLE -> RUN on start. On this transition: cnt, x and y are cleared to 0; best_eff is set to all-ones; best_raw, best_x and best_y are cleared to 0; early_en and thresh are latched; early_hit is cleared.
- In RUN, each sad_valid beat is one candidate. No backpressure: every beat in RUN is accepted.
- Effective SAD: eff = max(sad - ZMV_BIAS, 0) when x == RANGE and y == RANGE; otherwise eff = sad.
- Compare: update best when eff < best_eff (strict). On a tie the earlier candidate is kept.
- Counters: x increments per beat; at x == W-1 it wraps to 0 and y increments. cnt increments per beat. No divider is used.
- RUN -> DONE after a beat that is either the last candidate (cnt == NUM_CAND-1) or an early hit (latched early_en && eff <= latched thresh).
  - That beat's candidate is included in the best-match update in the same cycle.
  - On an early hit, stop pulses in the cycle immediately after the hit beat and early_hit is set.
  - If the last candidate is also an early hit, it counts as an early hit.
- DONE (one cycle): done = 1 and the result outputs are loaded from the best registers. Next state is IDLE.
- Latency: done rises exactly 1 cycle after the terminating sad_valid beat.
- Result outputs hold their values until the next start is accepted or reset.
- Ignored inputs:
  - start in RUN or DONE is ignored and is not queued.
  - sad_valid in IDLE or DONE is ignored, including beats after an early hit.
- Arithmetic: unsigned comparison. The bias subtraction saturates at 0 and never wraps. mv values are two's-complement.

Test Plan (RANGE=2 so W=5 and NUM_CAND=25; ZMV_BIAS=8; SAD_WIDTH=16; early_en=0 unless stated):
1. start, then 25 back-to-back beats all with SAD 100 except cnt 17 = 40 -> done 1 cycle after the 25th beat; min_cnt=17, min_sad=40, mv_x=0, mv_y=1, early_hit=0.
2. Ties: cnt 3 = 50 and cnt 9 = 50, all others 200 -> min_cnt=3, mv_x=1, mv_y=-2.
3. Bias: centre cnt 12 = 55, cnt 4 = 50, others 200 -> centre wins (47 < 50); min_sad=55, min_cnt=12, mv=(0,0). Saturation: centre SAD 5 gives eff 0 and the centre wins against any nonzero SAD.
4. Early termination: early_en=1, thresh=30; cnt 6 = 30, earlier candidates 90 -> stop pulses 1 cycle after beat 6 and done in the same cycle; min_cnt=6, min_sad=30, early_hit=1. Further beats are ignored and the outputs are unchanged.
5. Gapped stream with sad_valid toggling every other cycle, plus start pulses during RUN -> results identical to scenario 1; no restart occurs.
6. Assert rst after 10 beats -> next cycle busy=0 and all outputs 0; no done. A fresh start plus the scenario-1 stream gives the scenario-1 results.
